// File: rtl/delay_line_n_if.sv
// -----------------------------------------------------------------------------
// delay_line_n_if
// Sample-stream bundle for the programmable delay line.
//   in_valid   : sample strobe, one new sample per asserted cycle
//   sig_in     : input sample (BITWIDTH, two's complement, passed untouched)
//   delay_sel  : requested delay in samples (DSELW, one spare bit for
//                out-of-range requests)
//   out_valid  : one-cycle pulse one clock after each accepted sample
//   sig_out    : delayed sample, holds between out_valid pulses
//   clamp_flag : (only with DELAY_LINE_N_CLAMP_FLAG_EN) the sample's delay_sel
//                exceeded the buffer and was clamped
// master = sample source / sink side, slave = delay line.
// -----------------------------------------------------------------------------
interface delay_line_n_if #(
    parameter int BITWIDTH = 32,
    parameter int DSELW    = 7
);
    logic                in_valid;
    logic [BITWIDTH-1:0] sig_in;
    logic [DSELW-1:0]    delay_sel;
    logic                out_valid;
    logic [BITWIDTH-1:0] sig_out;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
    logic                clamp_flag;

    modport master (
        output in_valid, sig_in, delay_sel,
        input  out_valid, sig_out, clamp_flag
    );
    modport slave (
        input  in_valid, sig_in, delay_sel,
        output out_valid, sig_out, clamp_flag
    );
`else
    modport master (
        output in_valid, sig_in, delay_sel,
        input  out_valid, sig_out
    );
    modport slave (
        input  in_valid, sig_in, delay_sel,
        output out_valid, sig_out
    );
`endif
endinterface

// File: rtl/delay_line_n.sv
// -----------------------------------------------------------------------------
// delay_line_n
// Programmable integer sample delay z^-D, D = 0 .. DEPTH-1, selected per sample.
// A circular buffer is written once per accepted sample and read at a tap
// D_eff samples behind the write pointer.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high
//   bus  : delay_line_n_if.slave (in_valid, sig_in, delay_sel -> out_valid,
//          sig_out [, clamp_flag])
//
// Parameters: BITWIDTH (sample width), DEPTH (power of 2, >= 2),
//             DSELW (width of delay_sel, $clog2(DEPTH)+1).
//
// Optional feature macro: DELAY_LINE_N_CLAMP_FLAG_EN adds a registered
// clamp_flag output; without it requests above DEPTH-1 are clamped silently.
// -----------------------------------------------------------------------------
module delay_line_n #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 64,
    parameter int DSELW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    delay_line_n_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] addr_t;
    localparam addr_t            DMAX     = addr_t'(DEPTH - 1);
    localparam logic [DSELW-1:0] DMAX_SEL = DSELW'(DEPTH - 1);

    // Sample storage; no reset so it maps onto block RAM.
    logic [BITWIDTH-1:0] mem [DEPTH];
    logic [BITWIDTH-1:0] rd_data_q;

    addr_t wr_ptr_q, wr_ptr_d;
    addr_t fill_cnt_q, fill_cnt_d;
    addr_t d_eff;
    addr_t rd_addr;
    logic  accept;
    logic  clamp_req;

    logic                out_valid_q, out_valid_d;
    logic                zero_q, zero_d;        // output forced to 0 (priming / reset)
    logic                bypass_q, bypass_d;    // D_eff = 0: use the write-through copy
    logic [BITWIDTH-1:0] byp_data_q, byp_data_d;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
    logic                clamp_flag_q, clamp_flag_d;
`endif

    always_comb begin
        accept    = bus.in_valid & ~rst;
        clamp_req = (bus.delay_sel > DMAX_SEL);
        d_eff     = clamp_req ? DMAX : bus.delay_sel[AW-1:0];
        // Natural AW-bit wrap makes this track the write pointer's wrap.
        rd_addr   = wr_ptr_q - d_eff;

        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = accept;
        zero_d      = zero_q;
        bypass_d    = bypass_q;
        byp_data_d  = byp_data_q;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
        clamp_flag_d = clamp_flag_q;
`endif
        if (accept) begin
            wr_ptr_d   = wr_ptr_q + addr_t'(1);
            fill_cnt_d = (fill_cnt_q == DMAX) ? fill_cnt_q : fill_cnt_q + addr_t'(1);
            // fill_cnt_q counts samples written before this one, so a tap
            // further back than that would land on stale/undefined RAM.
            zero_d     = (d_eff > fill_cnt_q);
            bypass_d   = (d_eff == '0);
            byp_data_d = bus.sig_in;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
            clamp_flag_d = clamp_req;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            bypass_q    <= 1'b0;
            byp_data_q  <= '0;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
            clamp_flag_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            bypass_q    <= bypass_d;
            byp_data_q  <= byp_data_d;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
            clamp_flag_q <= clamp_flag_d;
`endif
        end
    end

    // Simple dual-port RAM, read-before-write on collision. The read register
    // is enabled only on accepted samples so sig_out holds while idle.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.sig_in;
            rd_data_q     <= mem[rd_addr];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sig_out   = zero_q   ? '0 :
                           bypass_q ? byp_data_q : rd_data_q;
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
    assign bus.clamp_flag = clamp_flag_q;
`endif

endmodule

// File: tb/tb_delay_line_n.sv
// -----------------------------------------------------------------------------
// tb_delay_line_n
// Scoreboard bench for delay_line_n. The stimulus side keeps the history of
// accepted samples since the last reset and pushes the expected output of each
// sample; an independent monitor pops and compares on every out_valid, and
// also checks out_valid timing and output hold between strobes.
// -----------------------------------------------------------------------------
module tb_delay_line_n;
    localparam int BW    = 32;
    localparam int DEPTH = 64;
    localparam int DSELW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_line_n_if #(.BITWIDTH(BW), .DSELW(DSELW)) bus ();

    delay_line_n #(.BITWIDTH(BW), .DEPTH(DEPTH), .DSELW(DSELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [BW-1:0] d;
        logic          c;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] hist[$];
    int            tests = 0;
    int            fails = 0;
    logic          mon_en = 1'b0;
    logic          exp_ov = 1'b0;
    logic          rst_prev = 1'b1;

    // Expected response from the definition: y[n] = x[n-D_eff], or 0 when
    // that sample was never accepted since reset.
    task automatic send(input logic [BW-1:0] x, input int dsel);
        int   deff;
        int   n;
        exp_t e;
        deff = (dsel > DEPTH - 1) ? DEPTH - 1 : dsel;
        hist.push_back(x);
        n = hist.size() - 1;
        e.d = (deff > n) ? '0 : hist[n - deff];
        e.c = (dsel > DEPTH - 1);
        sb.push_back(e);
        bus.in_valid  = 1'b1;
        bus.sig_in    = x;
        bus.delay_sel = DSELW'(dsel);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        hist.delete();
    endtask

    // Reference for out_valid: a pulse follows every accepted strobe.
    initial begin
        forever begin
            @(posedge clk);
            exp_ov   = bus.in_valid && !rst;
            rst_prev = rst;
        end
    end

    // Monitor
    initial begin
        logic [BW-1:0] last_d;
        logic          last_c;
        exp_t          e;
        last_d = '0;
        last_c = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_prev) begin
                    last_d = '0;
                    last_c = 1'b0;
                end
                tests++;
                if (bus.out_valid !== exp_ov) begin
                    fails++;
                    $display("[TB] FAIL out_valid: got %b want %b at %0t", bus.out_valid, exp_ov, $time);
                end
                if (bus.out_valid === 1'b1) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL sb_empty: got unexpected output %h want none", bus.sig_out);
                    end else begin
                        e = sb.pop_front();
                        if (bus.sig_out !== e.d) begin
                            fails++;
                            $display("[TB] FAIL sig_out: got %h want %h at %0t", bus.sig_out, e.d, $time);
                        end else begin
                            $display("[TB] out %h ok", bus.sig_out);
                        end
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
                        tests++;
                        if (bus.clamp_flag !== e.c) begin
                            fails++;
                            $display("[TB] FAIL clamp_flag: got %b want %b at %0t", bus.clamp_flag, e.c, $time);
                        end
`endif
                        last_d = e.d;
                        last_c = e.c;
                    end
                end else begin
                    tests++;
                    if (bus.sig_out !== last_d) begin
                        fails++;
                        $display("[TB] FAIL sig_out_hold: got %h want %h at %0t", bus.sig_out, last_d, $time);
                    end
`ifdef DELAY_LINE_N_CLAMP_FLAG_EN
                    tests++;
                    if (bus.clamp_flag !== last_c) begin
                        fails++;
                        $display("[TB] FAIL clamp_flag_hold: got %b want %b at %0t", bus.clamp_flag, last_c, $time);
                    end
`endif
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.sig_in    = '0;
        bus.delay_sel = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;          // reset state is checked from here on
        @(posedge clk); #1;
        rst = 1'b0;
        hist.delete();

        // Ramp with delay 5: five priming zeros, then 1,2,3...
        for (int i = 1; i <= 20; i++) send(BW'(i), 5);
        // Bypass
        send(32'hDEADBEEF, 0);
        idle(2);

        // Wrap and maximum delay
        do_reset(1);
        for (int n = 0; n < 200; n++) send(BW'(n), 63);
        idle(2);

        // Sparse strobes
        for (int i = 0; i < 12; i++) begin
            send($urandom, 2);
            idle(3);
        end

        // Clamp
        do_reset(1);
        for (int i = 0; i < 80; i++) send($urandom, 10);
        send($urandom, 100);
        send($urandom, 10);
        send($urandom, 127);
        idle(2);

        // Reset mid-stream
        do_reset(1);
        for (int i = 0; i < 30; i++) send($urandom, $urandom_range(0, 40));
        do_reset(1);
        for (int i = 0; i < 10; i++) send($urandom, 3);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 2));
            send($urandom, $urandom_range(0, 127));
        end
        idle(3);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
